// File: rtl/cipher_frame_buffer_if.sv
// cipher_frame_buffer_if: capture/replay signal bundle; parity_err exists only under CFB_PARITY_EN
interface cipher_frame_buffer_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              rd_req;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W:0]   frame_len;
   logic              frame_rdy;
   logic              busy;
   logic              overflow;
   logic              rd_done;
   logic              wr_drop;
`ifdef CFB_PARITY_EN
   logic              parity_err;
   modport master (output wr_valid, wr_data, rd_req,
                   input rd_valid, rd_data, frame_len, frame_rdy, busy, overflow, rd_done, wr_drop, parity_err);
   modport slave  (input wr_valid, wr_data, rd_req,
                   output rd_valid, rd_data, frame_len, frame_rdy, busy, overflow, rd_done, wr_drop, parity_err);
`else
   modport master (output wr_valid, wr_data, rd_req,
                   input rd_valid, rd_data, frame_len, frame_rdy, busy, overflow, rd_done, wr_drop);
   modport slave  (input wr_valid, wr_data, rd_req,
                   output rd_valid, rd_data, frame_len, frame_rdy, busy, overflow, rd_done, wr_drop);
`endif
endinterface

// File: rtl/cipher_frame_buffer.sv
// cipher_frame_buffer: capture one ciphertext frame and replay it on request; CFB_PARITY_EN adds stored parity and parity_err
module cipher_frame_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input logic                   clk,
   input logic                   rst,
   cipher_frame_buffer_if.slave  bus
);
`ifdef CFB_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif
   localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, CAPTURE, HOLD, REPLAY} state_t;
   state_t            state;
   logic [MEM_W-1:0]  mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr, rd_ptr, rd_idx;
   logic              start, wr_en, rd_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [MEM_W-1:0]  wr_word, rd_word;
   assign start   = bus.wr_valid && (state == IDLE || state == HOLD);
   assign wr_en   = rst && (start || (bus.wr_valid && state == CAPTURE && wr_ptr < FULL));
   assign wr_addr = start ? '0 : wr_ptr[ADDR_W-1:0];
   assign rd_en   = bus.rd_req && ((state == HOLD && !bus.wr_valid) ||
                                   (state == REPLAY && rd_ptr < bus.frame_len));
   assign rd_idx  = state == HOLD ? '0 : rd_ptr;
   assign rd_word = mem[rd_idx[ADDR_W-1:0]];
   assign bus.busy = state == CAPTURE || state == REPLAY;
`ifdef CFB_PARITY_EN
   logic parity_seen, mismatch;
   assign wr_word  = {^bus.wr_data, bus.wr_data};
   assign mismatch = rd_en && (rd_word[DATA_W] != ^rd_word[DATA_W-1:0]);
   always_ff @(posedge clk) begin
      if (!rst) begin
         parity_seen    <= 1'b0;
         bus.parity_err <= 1'b0;
      end else begin
         parity_seen    <= start ? 1'b0 : parity_seen | mismatch;
         bus.parity_err <= rd_en && (mismatch || parity_seen);
      end
   end
`else
   assign wr_word = bus.wr_data;
`endif
   always_ff @(posedge clk)
      if (wr_en) mem[wr_addr] <= wr_word;
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         bus.rd_valid  <= 1'b0;
         bus.rd_data   <= '0;
         bus.frame_len <= '0;
         bus.frame_rdy <= 1'b0;
         bus.overflow  <= 1'b0;
         bus.rd_done   <= 1'b0;
         bus.wr_drop   <= 1'b0;
      end else begin
         bus.rd_valid <= rd_en;
         bus.rd_data  <= rd_en ? rd_word[DATA_W-1:0] : '0;
         bus.rd_done  <= rd_en && (rd_idx + ONE == bus.frame_len);
         bus.wr_drop  <= state == REPLAY && bus.wr_valid;
         case (state)
            IDLE, HOLD:
               if (bus.wr_valid) begin
                  wr_ptr        <= ONE;
                  bus.frame_rdy <= 1'b0;
                  bus.overflow  <= 1'b0;
                  state         <= CAPTURE;
               end else if (state == HOLD && bus.rd_req) begin
                  rd_ptr <= ONE;
                  state  <= REPLAY;
               end
            CAPTURE:
               if (bus.wr_valid) begin
                  if (wr_ptr < FULL) wr_ptr <= wr_ptr + ONE;
                  else bus.overflow <= 1'b1;
               end else begin
                  bus.frame_len <= wr_ptr;
                  bus.frame_rdy <= 1'b1;
                  state         <= HOLD;
               end
            default:
               if (rd_en) rd_ptr <= rd_ptr + ONE;
               else begin
                  rd_ptr <= '0;
                  state  <= HOLD;
               end
         endcase
      end
   end
endmodule

// File: tb/tb_cipher_frame_buffer.sv
// tb_cipher_frame_buffer: directed capture/replay scenarios on a DEPTH=8 and a DEPTH=4 buffer in lockstep
module tb_cipher_frame_buffer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = '0;
   logic       rd_req = 1'b0;
   int         total = 0;
   int         bad = 0;
   always #5 clk = ~clk;
   cipher_frame_buffer_if #(.DATA_W(8), .ADDR_W(3)) a8 ();
   cipher_frame_buffer_if #(.DATA_W(8), .ADDR_W(2)) a4 ();
   assign a8.wr_valid = wr_valid;
   assign a8.wr_data  = wr_data;
   assign a8.rd_req   = rd_req;
   assign a4.wr_valid = wr_valid;
   assign a4.wr_data  = wr_data;
   assign a4.rd_req   = rd_req;
   cipher_frame_buffer #(.DATA_W(8), .DEPTH(8)) dut8 (.clk(clk), .rst(rst), .bus(a8));
   cipher_frame_buffer #(.DATA_W(8), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(a4));
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic see8(input string tag, input logic [5:0] flags, input logic [7:0] data);
      chk({tag, "_flags"}, {26'd0, a8.rd_valid, a8.rd_done, a8.wr_drop, a8.frame_rdy, a8.busy, a8.overflow}, {26'd0, flags});
      chk({tag, "_data"}, {24'd0, a8.rd_data}, {24'd0, data});
   endtask
   initial begin
      cyc();
      cyc();
      see8("reset", 6'b000000, 8'h00);
      chk("reset_len", a8.frame_len, 0);
      rst = 1'b1;
      cyc();
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'((i + 1) * 17);
         cyc();
         see8("cap5", 6'b000010, 8'h00);
      end
      wr_valid = 1'b0;
      cyc();
      see8("hold5", 6'b000100, 8'h00);
      chk("len5", a8.frame_len, 5);
      rd_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         see8("rep5", {1'b1, i == 4, 4'b0110}, 8'((i + 1) * 17));
      end
      rd_req = 1'b0;
      cyc();
      see8("rep5_end", 6'b000100, 8'h00);
      for (int i = 0; i < 6; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(8'hA0 + i);
         cyc();
      end
      wr_valid = 1'b0;
      cyc();
      chk("ovf_len4", a4.frame_len, 4);
      chk("ovf_flag4", a4.overflow, 1);
      chk("ovf_rdy4", a4.frame_rdy, 1);
      chk("ovf_len8", a8.frame_len, 6);
      chk("ovf_flag8", a8.overflow, 0);
      rd_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("ovf_rv", a4.rd_valid, 1);
         chk("ovf_data", a4.rd_data, 8'hA0 + i);
         chk("ovf_done", a4.rd_done, i == 3);
      end
      rd_req = 1'b0;
      cyc();
      chk("ovf_end_rv", a4.rd_valid, 0);
      chk("ovf_end_busy", a4.busy, 0);
      chk("ovf_sticky", a4.overflow, 1);
      for (int i = 0; i < 8; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(8'h31 + i);
         cyc();
         if (i == 0) chk("ovf_clear", a4.overflow, 0);
      end
      wr_valid = 1'b0;
      cyc();
      chk("len8", a8.frame_len, 8);
      see8("hold8", 6'b000100, 8'h00);
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         see8("part", 6'b100110, 8'(8'h31 + i));
      end
      rd_req = 1'b0;
      cyc();
      see8("abort", 6'b000100, 8'h00);
      rd_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         see8("restart", {1'b1, i == 7, 4'b0110}, 8'(8'h31 + i));
      end
      rd_req = 1'b0;
      cyc();
      for (int p = 0; p < 2; p++) begin
         rd_req = 1'b1;
         for (int i = 0; i < 8; i++) begin
            wr_valid = p == 0 && i == 2;
            wr_data  = 8'hFF;
            cyc();
            see8(p == 0 ? "drop_rep" : "drop_rep2", {1'b1, i == 7, p == 0 && i == 2, 3'b110}, 8'(8'h31 + i));
         end
         wr_valid = 1'b0;
         rd_req   = 1'b0;
         cyc();
         see8("drop_end", 6'b000100, 8'h00);
         chk("drop_len", a8.frame_len, 8);
      end
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      see8("pre_rst", 6'b100110, 8'h33);
      rst = 1'b0;
      cyc();
      see8("mid_rst", 6'b000000, 8'h00);
      chk("mid_rst_len", a8.frame_len, 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         see8("idle_req", 6'b000000, 8'h00);
      end
      rd_req = 1'b0;
`ifdef CFB_PARITY_EN
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1;
         wr_data  = 8'(8'h50 + i);
         cyc();
      end
      wr_valid = 1'b0;
      cyc();
      dut8.mem[3][0] = ~dut8.mem[3][0];
      rd_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("par_rv", a8.rd_valid, 1);
         chk("par_err", a8.parity_err, i == 3);
      end
      rd_req = 1'b0;
      cyc();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cipher_frame_buffer.md
Name: cipher_frame_buffer

Overview:
Parametrised ciphertext frame buffer between the encrypt and decrypt cores in the RC4 loopback top. It captures one contiguous ciphertext frame from the encryptor, holds it, and replays it word-by-word to the decryptor on request. It adds configurable width and depth, frame-length tracking, overflow protection, a replay-done pulse and repeatable replay.

Parameters:
DATA_W, 8, ciphertext word width in bits
DEPTH, 256, maximum words per frame (power of two, >=4)
ADDR_W, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
wr_valid  input  1  capture strobe; high for each ciphertext word of a frame, low ends the frame
wr_data  input  DATA_W  ciphertext word from encryptor
rd_req  input  1  replay request; held high for the whole replay
rd_valid  output  1  rd_data carries a replayed word (to decryptor valid)
rd_data  output  DATA_W  replayed word
frame_len  output  ADDR_W+1  length of the held frame (0..DEPTH)
frame_rdy  output  1  a complete frame is held and replayable
busy  output  1  state is CAPTURE or REPLAY
overflow  output  1  sticky; a word was dropped because the frame reached DEPTH
rd_done  output  1  one-cycle pulse with the last replayed word
wr_drop  output  1  one-cycle pulse; wr_valid was high during REPLAY and the word was discarded

Behaviour:
- Reset (rst=0 at an edge): state IDLE, wr_ptr=rd_ptr=0. All outputs are 0: rd_valid, rd_data, frame_len, frame_rdy, busy, overflow, rd_done, wr_drop. Memory contents are not cleared. Reset mid-capture or mid-replay aborts immediately.
- States: IDLE, CAPTURE, HOLD, REPLAY.
- IDLE: wr_valid=1 writes wr_data to mem[0], wr_ptr=1, frame_rdy=0, goes to CAPTURE. rd_req is ignored.
- CAPTURE, wr_valid=1 and wr_ptr<DEPTH: writes mem[wr_ptr] and increments wr_ptr.
- CAPTURE, wr_valid=1 and wr_ptr==DEPTH: drops the word and sets overflow. overflow clears only on reset or at the start of a new frame.
- CAPTURE, wr_valid=0: frame_len<=wr_ptr, frame_rdy<=1, goes to HOLD.
- HOLD, wr_valid=1: starts a new frame. Writes mem[0], wr_ptr=1, frame_rdy=0, overflow=0, goes to CAPTURE. wr_valid wins over a simultaneous rd_req.
- HOLD, rd_req=1: reads mem[0], rd_ptr=1, goes to REPLAY.
- Read latency: a word read at edge N appears on rd_data with rd_valid=1 after edge N (registered).
- REPLAY, rd_req=1 and rd_ptr<frame_len: reads mem[rd_ptr] and increments rd_ptr.
- REPLAY, word index frame_len-1 output: rd_done=1 in the same cycle. The next edge returns to HOLD with rd_ptr=0.
- REPLAY, rd_req=0 (abort): rd_ptr=0, goes to HOLD. The next request restarts from word 0.
- REPLAY, wr_valid=1: the word is discarded and wr_drop pulses. Memory is never overwritten during replay.
- A frame stays replayable any number of times until a new capture starts.
- Idle outputs: when rd_valid=0, rd_data=0.
- frame_len=DEPTH is representable, hence the ADDR_W+1 width. Pointers never wrap; they saturate at DEPTH.
- busy is combinational from state. All other outputs are registered.

Optional Feature:
- Macro: CFB_PARITY_EN.
- When defined: memory is DATA_W+1 bits wide and stores even parity of wr_data. On each replayed word, parity is recomputed. An extra output port, parity_err (1 bit), pulses high alongside rd_valid on a mismatch. A sticky parity_seen bit clears on reset or new frame, and is ORed into parity_err.
- When undefined: no parity storage, no parity_err port, behaviour otherwise identical.

Test Plan:
- Frame of 5 words: wr_valid high 5 cycles with 0x11,0x22,0x33,0x44,0x55, then low -> frame_len=5, frame_rdy=1. Then rd_req held high -> rd_valid high 5 cycles with 0x11..0x55, rd_done with 0x55, return to HOLD.
- Overflow, DEPTH=4: 6 words 0xA0..0xA5 -> frame_len=4, overflow=1, replay yields 0xA0..0xA3 only.
- Abort and restart, 8-word frame: drop rd_req after 3 rd_valid words -> rd_ptr reset. Re-assert -> replay restarts at word 0, all 8 words emitted.
- Write during replay: pulse wr_valid=1 with 0xFF mid-replay -> wr_drop=1 for one cycle, replayed data unchanged. Second replay is identical.
- Reset mid-replay: rst=0 during REPLAY word 2 -> next cycle all outputs 0, state IDLE. rd_req=1 afterwards produces no rd_valid.
- With CFB_PARITY_EN: force a bit flip in a stored word via hierarchical poke -> parity_err=1 on exactly that word's rd_valid cycle.
